// File: rtl/apb_cmd_master.sv
// apb_cmd_master
// Turns a valid/ready command stream into single APB3 transfers and returns
// a response stream with read data and error status. Only one transfer is
// outstanding at a time. Misaligned commands are answered without touching
// the bus. A transfer whose slave never raises pready is aborted after
// TIMEOUT_CYCLES ACCESS cycles; TIMEOUT_CYCLES=0 means wait forever.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_write         1=write, 0=read
//   cmd_addr          byte address (must be word aligned)
//   cmd_wdata         write data
//   rsp_valid/ready   response handshake
//   rsp_rdata         read data, 0 for good writes, ERR_RDATA on abort
//   rsp_err           pslverr, misalignment or timeout
//   rsp_timeout       the error was a timeout
//   psel, penable, pwrite, paddr, pwdata   APB request side
//   prdata, pready, pslverr                APB completion side
module apb_cmd_master #(
   parameter int unsigned       ADDR_W         = 32,
   parameter int unsigned       DATA_W         = 32,
   parameter int unsigned       TIMEOUT_CYCLES = 16,
   parameter logic [DATA_W-1:0] ERR_RDATA      = 32'hBADD_C0DE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   // A zero timeout still needs a one-bit counter to keep the code legal.
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
   localparam bit             TO_EN   = (TIMEOUT_CYCLES != 32'd0);
   localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    cnt_inc_s;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;

   assign cnt_inc_s = cnt_q + CNT_ONE;

   // Next-state and next-output logic; every output is computed one cycle
   // ahead so the ports come straight from flops.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cmd_ready_d   = cmd_ready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               pwrite_d    = cmd_write;
               paddr_d     = cmd_addr;
               pwdata_d    = cmd_wdata;
               if (cmd_addr[1:0] != 2'b00) begin
                  // Misaligned: answer directly, the bus never sees it.
                  state_d       = ST_RESP;
                  rsp_valid_d   = 1'b1;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b0;
                  rsp_rdata_d   = ERR_RDATA;
               end else begin
                  state_d = ST_SETUP;
                  psel_d  = 1'b1;
               end
            end else begin
               cmd_ready_d = 1'b1;
            end
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
         end
         ST_ACCESS: begin
            if (pready) begin
               // Completion takes priority over a timeout in the same cycle.
               state_d       = ST_RESP;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = pslverr;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = pwrite_q ? {DATA_W{1'b0}} : prdata;
            end else begin
               cnt_d = cnt_inc_s;
               if (TO_EN && (cnt_inc_s == TO_LIM)) begin
                  state_d       = ST_RESP;
                  psel_d        = 1'b0;
                  penable_d     = 1'b0;
                  rsp_valid_d   = 1'b1;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b1;
                  rsp_rdata_d   = ERR_RDATA;
               end else begin
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               cnt_d       = {CNT_W{1'b0}};
               cmd_ready_d = 1'b1;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b0;
            cnt_d       = {CNT_W{1'b0}};
            cmd_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= {CNT_W{1'b0}};
         cmd_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= {DATA_W{1'b0}};
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= {ADDR_W{1'b0}};
         pwdata_q      <= {DATA_W{1'b0}};
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Upstream stage for the per-block APB register slaves. Converts a simple valid/ready command stream (read/write, address, data) into single APB3 transfers on the block's apbReg bus.
- Returns a response stream carrying read data and error status.
- Owns the APB timing: setup/access phases, unlimited slave wait states, timeout abort, and pre-check of misaligned addresses.

Parameters:
- ADDR_W, 32, APB paddr and cmd_addr width.
- DATA_W, 32, APB pwdata/prdata and command/response data width.
- TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for pready before abort; 0 disables timeout. Counter width is clog2(TIMEOUT_CYCLES+1).
- ERR_RDATA, 32'hBADD_C0DE, rsp_rdata value returned on misaligned or timed-out transfers.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready.
- rsp_rdata  out  DATA_W  read data; 0 for successful writes.
- rsp_err  out  1  pslverr, misalignment or timeout.
- rsp_timeout  out  1  error was a timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE. cmd_ready=1. All other outputs are 0, including psel, penable, rsp_valid and paddr/pwdata/rsp_rdata. Timeout counter is 0.
- Reset asserted mid-transfer drops psel/penable on the next edge with no response generated. Any pending response is discarded.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1. On handshake, latch write/addr/wdata into paddr/pwrite/pwdata.
  - If cmd_addr[1:0]!=0: go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=ERR_RDATA. No APB activity.
  - Otherwise go to SETUP.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1. paddr/pwrite/pwdata are held stable.
  - If pready=1: capture rsp_err=pslverr and rsp_timeout=0. rsp_rdata = prdata for reads, 0 for writes. Go to RESP.
  - Else increment the counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES (i.e. TIMEOUT_CYCLES cycles without pready): go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=ERR_RDATA.
  - pready sampled in the same cycle as the timeout threshold wins: it is a normal completion.
- RESP:
  - psel=0, penable=0, rsp_valid=1. Response fields are stable until rsp_ready.
  - On handshake: clear rsp_valid, clear the counter, go to IDLE.
  - cmd_ready=0 in all non-IDLE states, so only one transfer is outstanding.
- Latency, aligned command accepted in cycle N with zero-wait slave:
  - SETUP in N+1.
  - ACCESS in N+2.
  - rsp_valid from N+3.
  - Next command accepted no earlier than the cycle after the response handshake.
  - Each slave wait state adds one cycle.
- Misaligned command accepted in N: rsp_valid in N+1.
- pslverr is ignored when pready=0. prdata is ignored on writes.
- With TIMEOUT_CYCLES=0, ACCESS waits indefinitely.

Test Plan:
- Zero-wait read, addr 0x0, slave prdata=0x0000_005A with pready in first ACCESS:
  - Expect psel at N+1, penable at N+2.
  - Expect rsp_valid at N+3 with rsp_rdata=0x5A, rsp_err=0.
- Write to 0x4, data 0x1234_5678, slave asserts pslverr with pready after 3 wait states:
  - pwdata/paddr stable throughout.
  - rsp_err=1, rsp_timeout=0, rsp_rdata=0, rsp_valid at N+6.
- Read of 0x8 with pready held 0, TIMEOUT_CYCLES=16:
  - Exactly 16 ACCESS cycles, then psel drops.
  - rsp_err=1, rsp_timeout=1, rsp_rdata=0xBADD_C0DE.
  - Repeat with pready=1 on the 16th ACCESS cycle: normal completion.
- Misaligned addr 0x2:
  - No psel ever.
  - rsp_valid next cycle with rsp_err=1, rsp_rdata=0xBADD_C0DE.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 queued:
  - cmd_ready stays 0 and response fields stay stable.
  - Second command is accepted the cycle after the rsp handshake.
- Reset asserted during ACCESS of a read:
  - Next edge: psel=penable=rsp_valid=0, cmd_ready=1.
  - No response emitted for the aborted read.
